integ_out_decimator: RTL and testbench
======================================

INTEG_OUT_DECIMATOR -- requirements
Module: integ_out_decimator

Interface
REQ-001 Parameter DEC_LOG2, default 2, log2 of decimation ratio N; legal values 1..6.
REQ-002 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  in_data is a new integrator output sample this cycle.
REQ-006 in_data  input  22  signed integrator output, sfix22_En20.
REQ-007 flush  input  1  synchronous clear of the partial accumulation.
REQ-008 out_ready  input  1  downstream accepts the head sample.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_data  output  12  signed decimated sample, sfix12_En10; FIFO head entry, 0 when empty.
REQ-011 ovf  output  1  sticky flag: a result was dropped because the FIFO was full.
REQ-012 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-013 Sample accepted when in_valid=1 at a rising edge; in_data ignored otherwise.
REQ-014 Accumulator width 22+DEC_LOG2 signed, sign-extends in_data; modulo-N sample counter.
REQ-015 On the Nth accepted sample, sum S = acc + in_data; average A = (S + 2^(DEC_LOG2-1)) >>> DEC_LOG2, truncated to 22 bits.
REQ-016 Format conversion: R = (A + 512) >>> 10 (round half up), saturated to [-2048, 2047].
REQ-017 R written into FIFO on the same edge as the Nth sample; accumulator and counter cleared on that edge.
REQ-018 Latency: out_valid rises one cycle after the edge that accepted the Nth sample when FIFO was empty.
REQ-019 Pop occurs when out_valid=1 and out_ready=1 at a rising edge; out_ready ignored when empty.
REQ-020 FIFO full and push without pop: R dropped, ovf set, FIFO contents unchanged.
REQ-021 FIFO full with push and pop same edge: both succeed, ovf unchanged.
REQ-022 FIFO empty with push: out_valid asserted next cycle with R on out_data; no same-cycle bypass.
REQ-023 flush=1: accumulator and counter cleared; in_valid in the same cycle is discarded; FIFO and ovf unaffected.
REQ-024 ovf_clr and a drop in the same cycle: ovf remains set (set wins).
REQ-025 Pointers wrap modulo FIFO_DEPTH; count register distinguishes full from empty.

Reset
REQ-026 reset=0 asynchronously clears accumulator, counter, FIFO pointers and count, and ovf.
REQ-027 During reset: out_valid=0, out_data=0, ovf=0; reset mid-accumulation discards partial sum.
REQ-028 Reset deassertion is synchronised externally; the block accepts in_valid from the first rising edge after deassertion.

Structure
REQ-029 Shared package integ_pkg holds IN_W=22, IN_FRAC=20, OUT_W=12, OUT_FRAC=10 and saturation limits.
REQ-030 One sub-module integ_fifo: synchronous FIFO with push, pop, full, empty, head data, parameterised width/depth.
REQ-031 Accumulator, rounding, and saturation logic stay in the top module.

Verification
REQ-032 N=4; four samples 0x000400 -> one result, out_data=0x001, out_valid one cycle after 4th sample.
REQ-033 Four samples 0x1FFFFF -> out_data=0x7FF (positive saturation); four 0x200000 -> out_data=0x800.
REQ-034 Four samples 0x000200 -> out_data=0x001; four samples 0x3FFE00 -> out_data=0x000 (round-half-up).
REQ-035 out_ready=0, 5 groups of 4 samples, FIFO_DEPTH=4 -> 4 entries held, 5th dropped, ovf=1; ovf_clr -> ovf=0.
REQ-036 Two samples, flush, four samples 0x000400 -> exactly one result, 0x001; reset asserted after 2 samples -> no output, out_valid=0.
REQ-037 FIFO full, out_ready=1 with 4th sample of next group on same edge -> count stays 4, ovf=0, order preserved.

Source files
------------

// File: rtl/integ_pkg.sv
// Shared formats and saturation helper for the integrator output decimator.
package integ_pkg;
  localparam int IN_W     = 22;
  localparam int IN_FRAC  = 20;
  localparam int OUT_W    = 12;
  localparam int OUT_FRAC = 10;

  localparam int SHIFT   = IN_FRAC - OUT_FRAC;
  localparam int RW      = IN_W - SHIFT + 1;
  localparam int RND_OFS = 1 << (SHIFT - 1);

  localparam logic signed [OUT_W-1:0] SAT_MAX = 12'sh7FF;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 12'sh800;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [RW-1:0] r);
    if (r > RW'(SAT_MAX))      return SAT_MAX;
    else if (r < RW'(SAT_MIN)) return SAT_MIN;
    else                       return r[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/integ_fifo.sv
// Synchronous FIFO; a push while full is dropped unless a pop happens on the same edge.
module integ_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/integ_out_decimator.sv
// Averages N integrator samples, rounds/saturates to sfix12_En10 and queues results.
module integ_out_decimator
  import integ_pkg::*;
#(
  parameter int DEC_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    flush,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    ovf,
  input  logic                    ovf_clr
);
  localparam int ACC_W = IN_W + DEC_LOG2;
  localparam int HALF  = 1 << (DEC_LOG2 - 1);

  logic signed [ACC_W-1:0]  acc, in_ext, sum, sum_rnd;
  logic [DEC_LOG2-1:0]      cnt;
  logic signed [IN_W-1:0]   avg;
  logic signed [IN_W:0]     avg_rnd;
  logic signed [RW-1:0]     r_wide;
  logic signed [OUT_W-1:0]  res;
  logic                     accept, last, full, empty, pop, drop;

  // ACC_W is exactly wide enough for N full-scale samples plus the rounding half.
  always_comb begin
    accept  = in_valid & ~flush;
    last    = accept & (cnt == '1);
    in_ext  = ACC_W'(in_data);
    sum     = acc + in_ext;
    sum_rnd = sum + ACC_W'(HALF);
    avg     = sum_rnd[ACC_W-1:DEC_LOG2];
    avg_rnd = (IN_W+1)'(avg) + (IN_W+1)'(RND_OFS);
    r_wide  = avg_rnd[IN_W:SHIFT];
    res     = sat_out(r_wide);
    pop     = out_ready & ~empty;
    drop    = last & full & ~pop;
    out_valid = ~empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= last ? '0 : sum;
      cnt <= cnt + DEC_LOG2'(1);
    end
  end

  // A drop on the same edge as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  integ_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (last),
    .pop   (pop),
    .din   (res),
    .full  (full),
    .empty (empty),
    .dout  (out_data)
  );
endmodule

// File: tb/tb_integ_out_decimator.sv
// Directed bench for integ_out_decimator with N=4 and a 4-entry FIFO.
module tb_integ_out_decimator;
  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready, ovf_clr;
  logic [21:0] in_data;
  logic        out_valid, ovf;
  logic [11:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  integ_out_decimator #(.DEC_LOG2(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    string       name;
    logic [21:0] s [4];
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [21:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic group(input logic [21:0] d);
    repeat (4) sample(d);
  endtask

  initial begin
    logic [11:0] exp_q [4];

    vecs[0] = '{"unity",     '{22'h000400, 22'h000400, 22'h000400, 22'h000400}, 12'h001};
    vecs[1] = '{"pos_sat",   '{22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF}, 12'h7FF};
    vecs[2] = '{"neg_sat",   '{22'h200000, 22'h200000, 22'h200000, 22'h200000}, 12'h800};
    vecs[3] = '{"half_up",   '{22'h000200, 22'h000200, 22'h000200, 22'h000200}, 12'h001};
    vecs[4] = '{"neg_half",  '{22'h3FFE00, 22'h3FFE00, 22'h3FFE00, 22'h3FFE00}, 12'h000};
    vecs[5] = '{"mixed",     '{22'h000400, 22'h000800, 22'h000C00, 22'h001000}, 12'h003};
    vecs[6] = '{"neg_one",   '{22'h3FFC00, 22'h3FFC00, 22'h3FFC00, 22'h3FFC00}, 12'hFFF};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 3; k++) sample(vecs[v].s[k]);
      chk({vecs[v].name, "_early"}, 32'(out_valid), 32'd0);
      sample(vecs[v].s[3]);
      chk({vecs[v].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[v].name, "_data"},  32'(out_data),  32'(vecs[v].exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({vecs[v].name, "_popped"}, 32'(out_valid), 32'd0);
    end

    // Fill the FIFO with 1,2,3,4 and drop a fifth result.
    for (int g = 1; g <= 5; g++) group(22'(g * 32'h400));
    chk("full_head", 32'(out_data), 32'd1);
    chk("ovf_set",   32'(ovf),      32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Drop and clear on the same edge: set wins.
    for (int k = 0; k < 3; k++) sample(22'h001C00);
    ovf_clr = 1'b1;
    sample(22'h001C00);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf), 32'd0);

    // Full FIFO: push and pop on the same edge.
    for (int k = 0; k < 3; k++) sample(22'h001800);
    out_ready = 1'b1;
    sample(22'h001800);
    out_ready = 1'b0;
    chk("pushpop_ovf", 32'(ovf), 32'd0);
    exp_q = '{12'h002, 12'h003, 12'h004, 12'h006};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain_data%0d", i),  32'(out_data),  32'(exp_q[i]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_zero",  32'(out_data),  32'd0);

    // Flush discards partial sum and a same-cycle sample.
    sample(22'h001C00);
    sample(22'h001C00);
    flush = 1'b1;
    sample(22'h001C00);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) sample(22'h000400);
    chk("flush_early", 32'(out_valid), 32'd0);
    sample(22'h000400);
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_data",  32'(out_data),  32'd1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("flush_single", 32'(out_valid), 32'd0);

    // Reset mid-accumulation.
    sample(22'h001C00);
    sample(22'h001C00);
    reset = 1'b0;
    #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    chk("midrst_ovf",   32'(ovf),       32'd0);
    step();
    reset = 1'b1;
    sample(22'h000400);
    sample(22'h000400);
    chk("midrst_noout", 32'(out_valid), 32'd0);
    sample(22'h000400);
    sample(22'h000400);
    chk("midrst_valid2", 32'(out_valid), 32'd1);
    chk("midrst_data2",  32'(out_data),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
